// File: rtl/conv_requant_fifo.sv
// conv_requant_fifo
// -----------------
// Requantisation stage behind the streaming convolution core.
// Each raw MAC result goes through these steps:
//   1. Add a signed per-channel bias.
//   2. Arithmetic right shift by SHIFT.
//   3. Saturate to an unsigned OUT_PREC value.
//   4. Push into a small FIFO that has a valid/ready handshake.
// Every RESULTS_PER_FRAME-th input is tagged as the last result of its frame.
//
// Build option:
//   CONV_REQUANT_ROUND_EN  defined   -> round half up before the shift
//                          undefined -> truncate (floor)
//
// Ports:
//   clk         clock
//   rst         synchronous active-high reset
//   in_data     unsigned conv result (IN_PREC)
//   in_valid    in_data valid this cycle; upstream cannot be stalled
//   bias        signed bias (BIAS_PREC), sampled together with in_data
//   out_data    FIFO head data, 0 when empty (OUT_PREC)
//   out_valid   FIFO non-empty
//   out_ready   consumer takes the head when out_valid & out_ready
//   out_last    head entry closes a frame, 0 when empty
//   overflow    sticky: a result was dropped into a full FIFO
//   fifo_count  occupied FIFO entries
module conv_requant_fifo #(
    parameter int IN_PREC           = 16,
    parameter int BIAS_PREC         = 16,
    parameter int OUT_PREC          = 8,
    parameter int SHIFT             = 4,
    parameter int FIFO_DEPTH        = 4,
    parameter int RESULTS_PER_FRAME = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [IN_PREC-1:0]              in_data,
    input  logic                            in_valid,
    input  logic [BIAS_PREC-1:0]            bias,
    output logic [OUT_PREC-1:0]             out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            out_last,
    output logic                            overflow,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

    // Two guard bits: one for the zero-extended unsigned input, one for the sum.
    localparam int SUM_W = ((IN_PREC > BIAS_PREC) ? IN_PREC : BIAS_PREC) + 2;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int FC_W  = (RESULTS_PER_FRAME > 1) ? $clog2(RESULTS_PER_FRAME) : 1;

    localparam logic [FC_W-1:0]     FC_LAST = FC_W'(RESULTS_PER_FRAME - 1);
    localparam logic [CNT_W-1:0]    CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [OUT_PREC-1:0] OUT_MAX = {OUT_PREC{1'b1}};

    // Saturate a signed shifted sum into the unsigned output range.
    function automatic logic [OUT_PREC-1:0] clamp_out(input logic signed [SUM_W-1:0] v);
        logic [OUT_PREC-1:0] r;
        if (v[SUM_W-1]) begin
            r = {OUT_PREC{1'b0}};
        end else if (|v[SUM_W-2:OUT_PREC]) begin
            r = OUT_MAX;
        end else begin
            r = v[OUT_PREC-1:0];
        end
        return r;
    endfunction

    // ---------------------------------------------------------------
    // Stage 1: bias addition and frame position
    // ---------------------------------------------------------------
    logic signed [SUM_W-1:0] in_ext_s;
    logic signed [SUM_W-1:0] bias_ext_s;
    logic signed [SUM_W-1:0] sum_s;
    logic signed [SUM_W-1:0] s1_sum_r;
    logic                    s1_valid_r;
    logic                    s1_last_r;
    logic [FC_W-1:0]         frame_cnt_r;

    // Widen input (zero-extend) and bias (sign-extend), then add.
    always_comb begin
        in_ext_s   = {{(SUM_W-IN_PREC){1'b0}}, in_data};
        bias_ext_s = {{(SUM_W-BIAS_PREC){bias[BIAS_PREC-1]}}, bias};
        sum_s      = in_ext_s + bias_ext_s;
    end

    // Stage-1 register. The frame counter also counts results that the
    // FIFO later drops, so frame alignment survives an overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_sum_r    <= {SUM_W{1'b0}};
            s1_valid_r  <= 1'b0;
            s1_last_r   <= 1'b0;
            frame_cnt_r <= {FC_W{1'b0}};
        end else begin
            s1_sum_r   <= sum_s;
            s1_valid_r <= in_valid;
            s1_last_r  <= in_valid && (frame_cnt_r == FC_LAST);
            if (in_valid) begin
                frame_cnt_r <= (frame_cnt_r == FC_LAST) ? {FC_W{1'b0}}
                                                        : frame_cnt_r + FC_W'(1);
            end else begin
                frame_cnt_r <= frame_cnt_r;
            end
        end
    end

    // ---------------------------------------------------------------
    // Stage 2: optional rounding, shift, saturation
    // ---------------------------------------------------------------
    logic signed [SUM_W-1:0] rnd_s;
    logic signed [SUM_W-1:0] shifted_s;
    logic [OUT_PREC-1:0]     s2_data_s;
    logic [OUT_PREC-1:0]     s2_data_r;
    logic                    s2_valid_r;
    logic                    s2_last_r;

`ifdef CONV_REQUANT_ROUND_EN
    // Half of one output LSB; evaluates to zero when SHIFT is 0.
    localparam logic signed [SUM_W-1:0] RND_C = SUM_W'((32'd1 << SHIFT) >> 1);
`endif

    // Round (if enabled), arithmetic shift, clamp.
    always_comb begin
`ifdef CONV_REQUANT_ROUND_EN
        rnd_s = s1_sum_r + RND_C;
`else
        rnd_s = s1_sum_r;
`endif
        shifted_s = rnd_s >>> SHIFT;
        s2_data_s = clamp_out(shifted_s);
    end

    // Stage-2 register.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_data_r  <= {OUT_PREC{1'b0}};
            s2_valid_r <= 1'b0;
            s2_last_r  <= 1'b0;
        end else begin
            s2_data_r  <= s2_data_s;
            s2_valid_r <= s1_valid_r;
            s2_last_r  <= s1_last_r;
        end
    end

    // ---------------------------------------------------------------
    // Output FIFO; each entry is {last, data}
    // ---------------------------------------------------------------
    logic [OUT_PREC:0]  mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic               overflow_r;
    logic               full_s;
    logic               pop_s;
    logic               wr_s;
    logic [OUT_PREC:0]  head_s;

    // Handshake decode. A pop in the same cycle makes room for a write
    // into a full FIFO.
    always_comb begin
        full_s = (count_r == CNT_FULL);
        pop_s  = (count_r != {CNT_W{1'b0}}) && out_ready;
        wr_s   = s2_valid_r && (!full_s || pop_s);
        head_s = mem_r[rd_ptr_r];
    end

    // Storage array.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {(OUT_PREC+1){1'b0}};
            end
        end else if (wr_s) begin
            mem_r[wr_ptr_r] <= {s2_last_r, s2_data_r};
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            wr_ptr_r <= wr_s  ? wr_ptr_r + PTR_W'(1) : wr_ptr_r;
            rd_ptr_r <= pop_s ? rd_ptr_r + PTR_W'(1) : rd_ptr_r;
            case ({wr_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
            overflow_r <= overflow_r || (s2_valid_r && full_s && !pop_s);
        end
    end

    // Outputs come from registers only; the head is masked while empty.
    assign out_valid  = (count_r != {CNT_W{1'b0}});
    assign out_data   = out_valid ? head_s[OUT_PREC-1:0] : {OUT_PREC{1'b0}};
    assign out_last   = out_valid && head_s[OUT_PREC];
    assign overflow   = overflow_r;
    assign fifo_count = count_r;

endmodule

// File: tb/tb_conv_requant_fifo.sv
// Directed bench for conv_requant_fifo with default parameters.
module tb_conv_requant_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_data;
    logic        in_valid;
    logic [15:0] bias;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        overflow;
    logic [2:0]  fifo_count;

    int checks   = 0;
    int failures = 0;

    logic [15:0] vd [16];
    logic [15:0] vb [16];
    logic [7:0]  ed [16];
    logic        el [16];

    conv_requant_fifo dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .bias       (bias),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = 16'd0; bias = 16'd0;
        step; step;
        rst = 1'b0;
    endtask

    // Drive n inputs back to back from vd/vb, no checking.
    task automatic send(input int n);
        for (int c = 0; c < n; c++) begin
            in_valid = 1'b1; in_data = vd[c]; bias = vb[c];
            step;
        end
        in_valid = 1'b0; in_data = 16'd0; bias = 16'd0;
    endtask

    // From an empty FIFO with out_ready=1: output k must appear exactly
    // 3 cycles after input k, then the FIFO must be empty again.
    task automatic stream_check(input int n);
        for (int c = 0; c < n + 2; c++) begin
            if (c < n) begin
                in_valid = 1'b1; in_data = vd[c]; bias = vb[c];
            end else begin
                in_valid = 1'b0; in_data = 16'd0; bias = 16'd0;
            end
            step;
            if (c < 2) begin
                check_eq("lat_early_valid", 32'(out_valid), 32'd0);
            end else begin
                check_eq("stream_valid", 32'(out_valid), 32'd1);
                check_eq("stream_data", 32'(out_data), 32'(ed[c-2]));
                check_eq("stream_last", 32'(out_last), 32'(el[c-2]));
            end
        end
        in_valid = 1'b0;
        step;
        check_eq("stream_drained", 32'(out_valid), 32'd0);
    endtask

    initial begin
        // Reset state
        do_reset;
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_data", 32'(out_data), 32'd0);
        check_eq("rst_last", 32'(out_last), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);
        check_eq("rst_count", 32'(fifo_count), 32'd0);

        // Rounding: 296/16 = 18.5
        do_reset;
        out_ready = 1'b1;
        vd[0] = 16'd296; vb[0] = 16'd0; el[0] = 1'b0;
`ifdef CONV_REQUANT_ROUND_EN
        ed[0] = 8'd19;
`else
        ed[0] = 8'd18;
`endif
        stream_check(1);

        // Saturation, negative clamp, exact in-range value
        do_reset;
        out_ready = 1'b1;
        vd[0] = 16'hFFFF; vb[0] = 16'd0;    ed[0] = 8'd255; el[0] = 1'b0;
        vd[1] = 16'd5;    vb[1] = 16'hFF9C; ed[1] = 8'd0;   el[1] = 1'b0;
        vd[2] = 16'd1000; vb[2] = 16'd24;   ed[2] = 8'd64;  el[2] = 1'b0;
        stream_check(3);

        // Backpressure and overflow: 6 inputs into a 4-deep FIFO
        do_reset;
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            vd[i] = 16'((i + 1) * 16); vb[i] = 16'd0;
        end
        send(6);
        step; step; step;
        check_eq("bp_count", 32'(fifo_count), 32'd4);
        check_eq("bp_ovf", 32'(overflow), 32'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check_eq("bp_data", 32'(out_data), 32'(k + 1));
            check_eq("bp_last", 32'(out_last), (k == 3) ? 32'd1 : 32'd0);
            step;
        end
        check_eq("bp_empty", 32'(out_valid), 32'd0);
        check_eq("bp_ovf_sticky", 32'(overflow), 32'd1);
        out_ready = 1'b0;

        // Full FIFO with a pop in the same cycle as a write
        do_reset;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            vd[i] = 16'((i + 1) * 16); vb[i] = 16'd0;
        end
        send(5);
        step;
        check_eq("fp_full", 32'(fifo_count), 32'd4);
        out_ready = 1'b1;
        step;
        out_ready = 1'b0;
        check_eq("fp_count", 32'(fifo_count), 32'd4);
        check_eq("fp_ovf", 32'(overflow), 32'd0);
        check_eq("fp_head", 32'(out_data), 32'd2);
        step;
        check_eq("fp_count_hold", 32'(fifo_count), 32'd4);
        check_eq("fp_ovf_hold", 32'(overflow), 32'd0);

        // Frame tagging: 8 back-to-back results
        do_reset;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            vd[i] = 16'((i + 1) * 16); vb[i] = 16'd0;
            ed[i] = 8'(i + 1); el[i] = ((i % 4) == 3);
        end
        stream_check(8);

        // Frame tagging across drops: results 5..8 dropped, 12th still tagged
        do_reset;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            vd[i] = 16'((i + 1) * 16); vb[i] = 16'd0;
        end
        send(8);
        step; step; step;
        check_eq("fd_ovf", 32'(overflow), 32'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check_eq("fd_data", 32'(out_data), 32'(k + 1));
            check_eq("fd_last", 32'(out_last), (k == 3) ? 32'd1 : 32'd0);
            step;
        end
        for (int i = 0; i < 4; i++) begin
            vd[i] = 16'((i + 9) * 16); vb[i] = 16'd0;
            ed[i] = 8'(i + 9); el[i] = (i == 3);
        end
        stream_check(4);

        // Reset in the middle of a burst with 3 entries queued
        do_reset;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            vd[i] = 16'((i + 1) * 16); vb[i] = 16'd0;
        end
        send(5);
        check_eq("mr_pre_count", 32'(fifo_count), 32'd3);
        rst = 1'b1;
        step;
        rst = 1'b0;
        check_eq("mr_valid", 32'(out_valid), 32'd0);
        check_eq("mr_count", 32'(fifo_count), 32'd0);
        check_eq("mr_ovf", 32'(overflow), 32'd0);
        step; step; step;
        check_eq("mr_flushed", 32'(fifo_count), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vd[i] = 16'((i + 3) * 16); vb[i] = 16'd0;
            ed[i] = 8'(i + 3); el[i] = (i == 3);
        end
        stream_check(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_requant_fifo.md
Name: conv_requant_fifo

Overview:
Downstream stage of the streaming convolution core. Consumes the raw multiply-accumulate result stream (data plus valid, no backpressure).
- Adds a per-channel bias, scales by an arithmetic right shift, and saturates to the output precision.
- Buffers results in a small FIFO with a valid/ready handshake toward the next layer or the DMA.
- Tags the last result of each frame.

Parameters:
IN_PREC, 16, width of the unsigned conv result (the conv core's OUTPUT_PREC)
BIAS_PREC, 16, width of the signed bias
OUT_PREC, 8, width of the unsigned requantized output
SHIFT, 4, right-shift amount, 0..IN_PREC-1
FIFO_DEPTH, 4, FIFO entries, power of two, minimum 2
RESULTS_PER_FRAME, 4, results per image (conv OUT_DIM*OUT_DIM)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_data  in  IN_PREC  unsigned conv result
in_valid  in  1  in_data valid this cycle; no ready; upstream never stalls
bias  in  BIAS_PREC  signed bias, sampled when in_valid=1
out_data  out  OUT_PREC  FIFO head; 0 when FIFO empty
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts head when out_valid&out_ready
out_last  out  1  head entry is the last result of a frame; 0 when empty
overflow  out  1  sticky: a result was dropped because the FIFO was full
fifo_count  out  $clog2(FIFO_DEPTH)+1  number of occupied entries

Behaviour:
- Reset (rst=1 at a clk edge): all outputs 0, FIFO pointers and count 0, frame counter 0, pipeline valids 0. In-flight results are discarded; overflow is cleared.

Stage 1 (registered):
- s1_sum = signed({1'b0,in_data}) + sign-extended bias.
- Width max(IN_PREC,BIAS_PREC)+2; no wrap possible.
- s1_valid <= in_valid.
- s1_last <= (frame_cnt == RESULTS_PER_FRAME-1).

Frame counter:
- Increments on every in_valid, wrapping to 0 after RESULTS_PER_FRAME-1.
- Advances even when the result is later dropped, so frame alignment is kept.

Stage 2 (registered):
- Shift: s1_sum >>> SHIFT, arithmetic (rounding per Optional Feature).
- Clamp: result <0 -> 0; result >2^OUT_PREC-1 -> 2^OUT_PREC-1; otherwise low OUT_PREC bits.
- Carries valid and last through.

FIFO:
- Write: s2_valid at a clk edge writes {last, data}.
- Pop: out_valid & out_ready.
- Full with no pop: write dropped and overflow <= 1, held until rst.
- Full with a simultaneous pop: write accepted, count unchanged.
- Empty: a pop is impossible (out_valid=0).
- Simultaneous write and pop when non-empty: count unchanged.
- Pointers wrap modulo FIFO_DEPTH.

Latency:
- in_valid high in cycle N -> out_valid high in cycle N+3 (FIFO empty, no stall).
- Sustained throughput: 1 result/cycle while out_ready=1.

Other:
- out_data/out_last come directly from the head register with no combinational path from in_data.
- bias may change every cycle; each result uses the bias sampled with it.

Optional Feature:
Macro: CONV_REQUANT_ROUND_EN.
- Defined: round half up. Add 2^(SHIFT-1) to s1_sum before the shift, in stage 2 with the same extended width; no addition when SHIFT=0.
- Undefined: truncation (floor via arithmetic shift).
- Latency, saturation and all other behaviour are identical with and without the macro.

Test Plan:
- Rounding: defaults, bias=0, out_ready=1, in_data=296. Without macro out_data=18; with macro out_data=19. In both cases out_valid rises 3 cycles after in_valid.
- Saturation and negative clamp: in_data=0xFFFF, bias=0 -> 255. in_data=5, bias=-100 -> 0. in_data=1000, bias=24 -> 64.
- Backpressure and overflow: out_ready=0, 6 consecutive inputs 16,32,..,96 (bias 0). Expect fifo_count=4 and overflow=1. Then out_ready=1 drains 1,2,3,4 in order, and overflow stays 1.
- Full with simultaneous pop: FIFO full, out_ready=1 and a new write in the same cycle -> no drop, overflow stays 0, fifo_count stays 4.
- Frame tagging: 8 back-to-back inputs with out_ready=1 -> out_last=1 only on outputs 4 and 8. A result dropped in position 4 still counts, so output 8 remains tagged.
- Reset mid-operation: rst during an in-flight burst with the FIFO at 3 -> next cycle out_valid=0, fifo_count=0, overflow=0. The next frame's 4th input is tagged last.
